// File: rtl/spi_byte_receiver_if.sv
// Byte stream handshake between spi_byte_receiver and its consumer.
// The master drives data/valid and the slave answers with ready.
interface spi_byte_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/spi_byte_receiver.sv
// Load-framed serial byte receiver with clk-domain oversampling,
// a small byte FIFO and frame/overflow status reporting.
module spi_byte_receiver #(
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sck,
  input  logic                sdi,
  input  logic                load,
  spi_byte_receiver_if.master rx,
  output logic                frame_done,
  output logic                partial_err,
  output logic                overflow,
  output logic [7:0]          byte_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(DEPTH);

  typedef enum logic {
    S_IDLE,
    S_RECV
  } state_t;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_sdi_sync;
  logic [SYNC_STAGES-1:0] r_load_sync;
  logic                   r_sck_d;

  state_t     r_state;
  logic [7:0] r_shift;
  logic [2:0] r_bit_cnt;
  logic [7:0] r_byte_cnt;
  logic       r_frame_done;
  logic       r_partial;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  logic [7:0]    r_last;
  logic          r_overflow;

  logic       w_sck_s;
  logic       w_sdi_s;
  logic       w_load_s;
  logic       w_rise;
  logic [7:0] w_byte;
  logic       w_push;
  logic       w_pop;
  logic       w_full;
  logic       w_empty;
  logic       w_wr;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_sdi_s  = r_sdi_sync[SYNC_STAGES-1];
  assign w_load_s = r_load_sync[SYNC_STAGES-1];
  assign w_rise   = w_sck_s & ~r_sck_d;
  assign w_byte   = {r_shift[6:0], w_sdi_s};

  assign w_push = (r_state == S_RECV) & w_load_s
                & w_rise & (r_bit_cnt == 3'd7);
  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL);
  assign w_pop   = ~w_empty & rx.rx_ready;
  // A full FIFO still accepts a byte when the head leaves this cycle.
  assign w_wr    = w_push & (~w_full | w_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= '0;
      r_sdi_sync  <= '0;
      r_load_sync <= '0;
      r_sck_d     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
      r_sdi_sync  <= {r_sdi_sync[SYNC_STAGES-2:0], sdi};
      r_load_sync <= {r_load_sync[SYNC_STAGES-2:0], load};
      r_sck_d     <= w_sck_s;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_shift      <= '0;
      r_bit_cnt    <= '0;
      r_byte_cnt   <= '0;
      r_frame_done <= 1'b0;
      r_partial    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;
      r_partial    <= 1'b0;
      unique case (r_state)
        S_IDLE: begin
          if (w_load_s) begin
            r_state    <= S_RECV;
            r_shift    <= '0;
            r_bit_cnt  <= '0;
            r_byte_cnt <= '0;
          end
        end
        S_RECV: begin
          if (!w_load_s) begin
            r_state      <= S_IDLE;
            r_frame_done <= 1'b1;
            r_partial    <= (r_bit_cnt != 3'd0);
          end else if (w_rise) begin
            r_shift   <= w_byte;
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7 && r_byte_cnt != 8'hFF)
              r_byte_cnt <= r_byte_cnt + 8'd1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++)
        r_mem[i] <= '0;
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_last     <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_wr) begin
        r_mem[r_wptr] <= w_byte;
        r_wptr        <= r_wptr + 1'b1;
      end
      if (w_push && !w_wr)
        r_overflow <= 1'b1;
      if (w_pop) begin
        r_rptr <= r_rptr + 1'b1;
        r_last <= r_mem[r_rptr];
      end
      unique case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Once empty, keep showing the last byte handed out.
  assign rx.rx_data  = w_empty ? r_last : r_mem[r_rptr];
  assign rx.rx_valid = ~w_empty;
  assign frame_done  = r_frame_done;
  assign partial_err = r_partial;
  assign overflow    = r_overflow;
  assign byte_count  = r_byte_cnt;

endmodule
